// File: rtl/fp_multiply_6bit_pkg.sv
// Shared constants, derived widths, FSM state type and exponent helper
// for the 6-bit sign/exponent/mantissa multiplier.
package fp_multiply_6bit_pkg;

  localparam int MANT_W = 6;
  localparam int EXP_W  = 5;
  localparam int PROD_W = 2 * MANT_W;
  localparam int ESUM_W = EXP_W + 1;
  localparam int CNT_W  = 3;

  // Index of the final multiplier bit examined by the shift-and-add engine.
  localparam logic [CNT_W-1:0] LAST_ITER = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MULT   = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  // Zero-extended exponent add; the top bit is the carry out of the EXP_W add.
  function automatic logic [ESUM_W-1:0] exp_sum(input logic [EXP_W-1:0] a,
                                                input logic [EXP_W-1:0] b);
    exp_sum = {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/fp_multiply_6bit_shift_add.sv
// Iterative shift-and-add mantissa multiplier: one multiplier bit per cycle,
// LSB first, with its own start/done handshake.
import fp_multiply_6bit_pkg::*;

module shift_add_mult_6bit (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [MANT_W-1:0] multiplicand,
  input  logic [MANT_W-1:0] multiplier,
  output logic              last_iter,
  output logic              done,
  output logic [PROD_W-1:0] product
);

  logic              run_q,    run_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;
  logic [MANT_W-1:0] mcand_q,  mcand_d;
  logic [MANT_W-1:0] mplier_q, mplier_d;
  logic [PROD_W-1:0] acc_q,    acc_d;
  logic              done_q,   done_d;
  logic [PROD_W-1:0] addend_s;
  logic              last_iter_s;

  // Partial product for the current iteration and final-iteration detect.
  always_comb begin
    addend_s    = PROD_W'(mcand_q) << cnt_q;
    last_iter_s = run_q && (cnt_q == LAST_ITER);
  end

  // Next-state logic: latch on start, then accumulate one bit per cycle.
  always_comb begin
    run_d    = run_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    done_d   = 1'b0;
    if (start && !run_q) begin
      run_d    = 1'b1;
      cnt_d    = {CNT_W{1'b0}};
      mcand_d  = multiplicand;
      mplier_d = multiplier;
      acc_d    = {PROD_W{1'b0}};
    end else if (run_q) begin
      if (mplier_q[cnt_q]) begin
        acc_d = acc_q + addend_s;
      end else begin
        acc_d = acc_q;
      end
      if (last_iter_s) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 3'd1;
      end
    end else begin
      run_d = 1'b0;
    end
  end

  // Engine state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_q    <= 1'b0;
      cnt_q    <= {CNT_W{1'b0}};
      mcand_q  <= {MANT_W{1'b0}};
      mplier_q <= {MANT_W{1'b0}};
      acc_q    <= {PROD_W{1'b0}};
      done_q   <= 1'b0;
    end else begin
      run_q    <= run_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      done_q   <= done_d;
    end
  end

  assign last_iter = last_iter_s;
  assign done      = done_q;
  assign product   = acc_q;

endmodule

// File: rtl/fp_multiply_6bit.sv
// Sign/exponent/mantissa multiplier top: latches operands on Start, runs the
// shift-and-add mantissa engine and publishes all results together with Done.
import fp_multiply_6bit_pkg::*;

module fp_multiply_6bit (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Start,
  input  logic              SignA,
  input  logic              SignB,
  input  logic [EXP_W-1:0]  ExponentA,
  input  logic [EXP_W-1:0]  ExponentB,
  input  logic [MANT_W-1:0] MantissaA,
  input  logic [MANT_W-1:0] MantissaB,
  output logic              Busy,
  output logic              Done,
  output logic              SignOut,
  output logic [ESUM_W-1:0] ExponentOut,
  output logic              ExponentC,
  output logic [PROD_W-1:0] MantissaOut
);

  state_e            state_q, state_d;
  logic              busy_q,  busy_d;
  logic              done_q,  done_d;
  logic              sa_q,    sa_d;
  logic              sb_q,    sb_d;
  logic [EXP_W-1:0]  ea_q,    ea_d;
  logic [EXP_W-1:0]  eb_q,    eb_d;
  logic              sign_q,  sign_d;
  logic [ESUM_W-1:0] exp_q,   exp_d;
  logic [PROD_W-1:0] mant_q,  mant_d;

  logic              eng_start_s;
  logic              eng_last_s;
  logic              eng_done_s;
  logic [PROD_W-1:0] eng_prod_s;

  // The engine only accepts a request when the top is idle, so Start while
  // busy never disturbs the running multiply.
  always_comb begin
    eng_start_s = Start && (state_q == ST_IDLE);
  end

  shift_add_mult_6bit u_engine (
    .clk          (CLK),
    .rst          (RST),
    .start        (eng_start_s),
    .multiplicand (MantissaA),
    .multiplier   (MantissaB),
    .last_iter    (eng_last_s),
    .done         (eng_done_s),
    .product      (eng_prod_s)
  );

  // FSM next-state and result register updates.
  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sa_d    = sa_q;
    sb_d    = sb_q;
    ea_d    = ea_q;
    eb_d    = eb_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    mant_d  = mant_q;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          sa_d    = SignA;
          sb_d    = SignB;
          ea_d    = ExponentA;
          eb_d    = ExponentB;
          busy_d  = 1'b1;
          state_d = ST_MULT;
        end else begin
          busy_d  = 1'b0;
        end
      end
      ST_MULT: begin
        if (eng_last_s) begin
          state_d = ST_FINISH;
        end else begin
          state_d = ST_MULT;
        end
      end
      ST_FINISH: begin
        // Engine done coincides with this state; results are published
        // in one step so outputs never show a partial product.
        if (eng_done_s) begin
          sign_d  = sa_q ^ sb_q;
          exp_d   = exp_sum(ea_q, eb_q);
          mant_d  = eng_prod_s;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_FINISH;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset wins over Start.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      ea_q    <= {EXP_W{1'b0}};
      eb_q    <= {EXP_W{1'b0}};
      sign_q  <= 1'b0;
      exp_q   <= {ESUM_W{1'b0}};
      mant_q  <= {PROD_W{1'b0}};
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      ea_q    <= ea_d;
      eb_q    <= eb_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      mant_q  <= mant_d;
    end
  end

  assign Busy        = busy_q;
  assign Done        = done_q;
  assign SignOut     = sign_q;
  assign ExponentOut = exp_q;
  assign ExponentC   = exp_q[ESUM_W-1];
  assign MantissaOut = mant_q;

endmodule

// File: tb/tb_fp_multiply_6bit.sv
// Scoreboard bench for fp_multiply_6bit: stimulus pushes expected results,
// a monitor pops and compares whenever Done is seen.
module tb_fp_multiply_6bit;

  logic        CLK;
  logic        RST;
  logic        Start;
  logic        SignA, SignB;
  logic [4:0]  ExponentA, ExponentB;
  logic [5:0]  MantissaA, MantissaB;
  logic        Busy, Done, SignOut, ExponentC;
  logic [5:0]  ExponentOut;
  logic [11:0] MantissaOut;

  typedef struct {
    int sign;
    int expo;
    int mant;
    int cyc;
  } exp_t;

  exp_t sb_q[$];
  int   cyc;
  int   n_checks;
  int   n_fail;

  fp_multiply_6bit dut (
    .CLK         (CLK),
    .RST         (RST),
    .Start       (Start),
    .SignA       (SignA),
    .SignB       (SignB),
    .ExponentA   (ExponentA),
    .ExponentB   (ExponentB),
    .MantissaA   (MantissaA),
    .MantissaB   (MantissaB),
    .Busy        (Busy),
    .Done        (Done),
    .SignOut     (SignOut),
    .ExponentOut (ExponentOut),
    .ExponentC   (ExponentC),
    .MantissaOut (MantissaOut)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  initial begin
    bit   r;
    exp_t e;
    int   h_sign, h_exp, h_mant;
    cyc    = 0;
    h_sign = 0;
    h_exp  = 0;
    h_mant = 0;
    forever begin
      @(posedge CLK);
      cyc++;
      r = RST;
      #1;
      if (r) begin
        sb_q.delete();
        h_sign = 0;
        h_exp  = 0;
        h_mant = 0;
        chk("reset_busy", int'(Busy), 0);
        chk("reset_done", int'(Done), 0);
        chk("reset_sign", int'(SignOut), 0);
        chk("reset_exp", int'(ExponentOut), 0);
        chk("reset_expc", int'(ExponentC), 0);
        chk("reset_mant", int'(MantissaOut), 0);
      end else begin
        if (Done) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            e = sb_q.pop_front();
            chk("done_cycle", cyc, e.cyc);
            chk("sign", int'(SignOut), e.sign);
            chk("exponent", int'(ExponentOut), e.expo);
            chk("exp_carry", int'(ExponentC), e.expo / 32);
            chk("mantissa", int'(MantissaOut), e.mant);
            h_sign = e.sign;
            h_exp  = e.expo;
            h_mant = e.mant;
          end
        end else begin
          chk("hold_sign", int'(SignOut), h_sign);
          chk("hold_exp", int'(ExponentOut), h_exp);
          chk("hold_mant", int'(MantissaOut), h_mant);
        end
        chk("busy", int'(Busy), (sb_q.size() != 0) ? 1 : 0);
      end
    end
  end

  // Drive operands and Start at the current falling edge; record expectation.
  task automatic set_ops(input int sa, input int sb, input int ea, input int eb,
                         input int ma, input int mb);
    exp_t e;
    SignA     = sa[0];
    SignB     = sb[0];
    ExponentA = ea[4:0];
    ExponentB = eb[4:0];
    MantissaA = ma[5:0];
    MantissaB = mb[5:0];
    Start     = 1'b1;
    e.sign = sa ^ sb;
    e.expo = ea + eb;
    e.mant = ma * mb;
    e.cyc  = cyc + 1 + 7;
    sb_q.push_back(e);
  endtask

  task automatic issue(input int sa, input int sb, input int ea, input int eb,
                       input int ma, input int mb);
    @(negedge CLK);
    set_ops(sa, sb, ea, eb, ma, mb);
    @(negedge CLK);
    Start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    if (sb_q.size() != 0) begin
      chk("done_timeout", 0, 1);
      sb_q.delete();
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    RST       = 1'b1;
    Start     = 1'b0;
    SignA     = 1'b0;
    SignB     = 1'b0;
    ExponentA = 5'd0;
    ExponentB = 5'd0;
    MantissaA = 6'd0;
    MantissaB = 6'd0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;

    // Directed cases.
    issue(1, 0, 3, 6, 7, 9);
    wait_idle();
    issue(1, 1, 31, 31, 63, 63);
    wait_idle();
    issue(0, 1, 16, 16, 0, 45);
    wait_idle();

    // Start pulsed mid-operation with changed operands: ignored.
    issue(0, 1, 10, 12, 13, 11);
    SignA     = 1'b1;
    SignB     = 1'b1;
    ExponentA = 5'd1;
    ExponentB = 5'd1;
    MantissaA = 6'd2;
    MantissaB = 6'd2;
    @(negedge CLK);
    Start = 1'b1;
    @(negedge CLK);
    Start = 1'b0;
    wait_idle();

    // Reset at edge N+3 aborts the multiply.
    issue(1, 0, 20, 5, 33, 29);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    repeat (8) @(negedge CLK);
    issue(0, 0, 2, 2, 5, 5);
    wait_idle();

    // Back-to-back with Start held high: Done every 8 cycles.
    @(negedge CLK);
    for (int k = 0; k < 4; k++) begin
      set_ops($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 31),
              $urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 63));
      repeat (8) @(negedge CLK);
    end
    Start = 1'b0;
    wait_idle();

    // Randomized operations with random idle gaps.
    for (int i = 0; i < 25; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge CLK);
      issue($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 31),
            $urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 63));
      wait_idle();
    end

    repeat (4) @(negedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
